// File: rtl/seg7_pkg.sv
// Shared types and constants for the 2-digit 7-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    UNITS = 2'd0,
    GAP_T = 2'd1,
    TENS  = 2'd2,
    GAP_U = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  // Entry 15 first; codes 10-15 are not BCD and render as a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational 4-bit code to active-low 7-segment pattern lookup.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  assign pattern = seg_pattern(code);

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit common-anode 7-segment scanner with anti-ghost gap cycles,
// leading-zero blanking and busy tracking. Optional blinking: SEG7_BLINK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       busy
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  scan_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [6:0] seg_reg, seg_next;
  logic [1:0] an_reg, an_next;
  logic busy_reg, clean_reg, units_done_reg;
  logic in_gap, tick, suppress;

  logic [3:0] digit_in   [2];
  logic [6:0] digit_pat  [2];
  logic       digit_zero [2];

  assign digit_in[0] = units;
  assign digit_in[1] = tens;

  assign in_gap = (state_reg == GAP_T) || (state_reg == GAP_U);
  assign tick   = !in_gap && (cnt_reg == CNT_LAST);

  // Index 0 is the units digit, index 1 the tens digit.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      logic [3:0] digit_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          digit_reg <= 4'd0;
        end else if (load) begin
          digit_reg <= digit_in[gi];
        end
      end

      bcd_to_seg7 u_dec (
        .code    (digit_reg),
        .pattern (digit_pat[gi])
      );

      assign digit_zero[gi] = (digit_reg == 4'd0);
    end
  endgenerate

`ifdef SEG7_BLINK_EN
  localparam int BDIV_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BDIV_W-1:0] BDIV_LAST = BDIV_W'(BLINK_DIV - 1);

  logic [BDIV_W-1:0] bcnt_reg;
  logic              phase_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (tick) begin
      if (bcnt_reg == BDIV_LAST) begin
        bcnt_reg  <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        bcnt_reg <= bcnt_reg + 1'b1;
      end
    end
  end

  assign suppress = blink & phase_reg;
`else
  logic [31:0] unused_blink_cfg;
  assign unused_blink_cfg = {blink, 31'(BLINK_DIV)};
  assign suppress = 1'b0;
`endif

  // Dwell counter is held at zero through the gap so each dwell starts fresh.
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (in_gap || tick) begin
      cnt_next = '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    an_next    = AN_OFF;
    seg_next   = SEG_OFF;

    case (state_reg)
      UNITS:   if (tick) state_next = GAP_T;
      GAP_T:   state_next = TENS;
      TENS:    if (tick) state_next = GAP_U;
      GAP_U:   state_next = UNITS;
      default: state_next = UNITS;
    endcase

    case (state_next)
      UNITS: begin
        an_next  = AN_UNITS;
        seg_next = digit_pat[0];
      end
      TENS: begin
        an_next  = AN_TENS;
        seg_next = digit_zero[1] ? SEG_OFF : digit_pat[1];
      end
      default: begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
      end
    endcase

    if (suppress) begin
      seg_next = SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= UNITS;
      cnt_reg   <= '0;
      seg_reg   <= SEG_OFF;
      an_reg    <= AN_OFF;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
    end
  end

  // clean_reg: the current dwell has shown only the latest loaded value
  // from its first cycle. A load on the dwell-entry edge spoils that dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg       <= 1'b0;
      clean_reg      <= 1'b0;
      units_done_reg <= 1'b0;
    end else if (load) begin
      busy_reg       <= 1'b1;
      clean_reg      <= 1'b0;
      units_done_reg <= 1'b0;
    end else begin
      if (in_gap) begin
        clean_reg <= 1'b1;
      end
      if ((state_reg == UNITS) && tick && clean_reg) begin
        units_done_reg <= 1'b1;
      end
      if ((state_reg == TENS) && tick && clean_reg && units_done_reg) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign seg  = seg_reg;
  assign an   = an_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with PRESCALE=4, BLINK_DIV=2.
// Define SEG7_BLINK_EN for both DUT and bench to exercise blinking.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] units;
  logic [3:0] tens;
  logic       blink;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy;

  int n_vec  = 0;
  int n_bad  = 0;
  int an_bad = 0;
  bit d [8];
  int n_dark;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .PRESCALE  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .units (units),
    .tens  (tens),
    .blink (blink),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  // Both anodes on at once would ghost; watch for it the whole run.
  always @(negedge clk) begin
    if (an === 2'b00) an_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input logic [1:0] tgt, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (an === tgt) hit = 1'b1;
    end
    check(tag, 32'(an), 32'(tgt));
  endtask

  task automatic do_load(input logic [3:0] u, input logic [3:0] t);
    $display("load units=%0d tens=%0d at %0t", u, t, $time);
    load  = 1'b1;
    units = u;
    tens  = t;
    step();
    load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_an;
    logic [6:0] exp_seg;

    rst = 1'b1; load = 1'b0; blink = 1'b0; units = 4'd0; tens = 4'd0;
    repeat (3) step();
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'h3);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Scan sequence for 74
    do_load(4'd7, 4'd4);
    check("busy_set", 32'(busy), 32'h1);
    wait_an(2'b11, "sync_gap");
    wait_an(2'b01, "sync_tens");
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      if (k < 4)       begin exp_an = 2'b01; exp_seg = 7'b0011001; end
      else if (k == 4) begin exp_an = 2'b11; exp_seg = 7'h7F;      end
      else if (k < 9)  begin exp_an = 2'b10; exp_seg = 7'b1111000; end
      else             begin exp_an = 2'b11; exp_seg = 7'h7F;      end
      check($sformatf("scan_an_%0d", k), 32'(an), 32'(exp_an));
      check($sformatf("scan_seg_%0d", k), 32'(seg), 32'(exp_seg));
    end
    step();
    check("scan_period", 32'(an), 32'h1);

    // Leading-zero blanking and invalid codes
    wait_an(2'b11, "b_gap");
    wait_an(2'b10, "b_units");
    do_load(4'd3, 4'd0);
    wait_an(2'b01, "b_tens");
    check("blank_tens", 32'(seg), 32'h7F);
    step();
    check("blank_tens_mid_an", 32'(an), 32'h1);
    check("blank_tens_mid", 32'(seg), 32'h7F);
    wait_an(2'b10, "b_units2");
    check("units3", 32'(seg), 32'h30);
    do_load(4'd3, 4'd12);
    wait_an(2'b01, "d_tens");
    check("dash_tens", 32'(seg), 32'h3F);
    wait_an(2'b10, "d_units");
    do_load(4'd15, 4'd5);
    check("units_old_latency", 32'(seg), 32'h30);
    step();
    check("units_dash", 32'(seg), 32'h3F);

    // Load during UNITS dwell and busy clearing
    wait_an(2'b11, "l_gap");
    wait_an(2'b10, "l_units");
    do_load(4'd7, 4'd4);
    wait_an(2'b11, "l_gap2");
    wait_an(2'b10, "l_units2");
    check("units7", 32'(seg), 32'h78);
    do_load(4'd2, 4'd4);
    check("pre_update", 32'(seg), 32'h78);
    check("busy_after_load", 32'(busy), 32'h1);
    step();
    check("units2", 32'(seg), 32'h24);
    wait_an(2'b01, "bz_tens");
    wait_an(2'b11, "bz_gapu");
    check("busy_hold_gapu", 32'(busy), 32'h1);
    wait_an(2'b10, "bz_units");
    wait_an(2'b01, "bz_tens2");
    check("busy_before_clear", 32'(busy), 32'h1);
    wait_an(2'b11, "bz_gapu2");
    check("busy_clear", 32'(busy), 32'h0);

    // Asynchronous reset mid-dwell
    do_load(4'd9, 4'd9);
    step();
    rst = 1'b1;
    #1;
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_an", 32'(an), 32'h3);
    check("async_rst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_an", 32'(an), 32'h2);
    check("post_rst_units", 32'(seg), 32'h40);
    wait_an(2'b01, "post_rst_tens_an");
    check("post_rst_tens_blank", 32'(seg), 32'h7F);

    // Blink behaviour
    do_load(4'd7, 4'd4);
    wait_an(2'b11, "bl_gap");
    wait_an(2'b11, "bl_gap2");
    blink = 1'b1;
    n_dark = 0;
    for (int i = 0; i < 8; i++) begin
      wait_an(2'b11, $sformatf("bl_scan_gap_%0d", i));
      step();
      d[i] = (seg === 7'h7F);
      if (d[i]) n_dark++;
`ifndef SEG7_BLINK_EN
      check($sformatf("no_blink_dark_%0d", i), 32'(d[i]), 32'h0);
`endif
    end
`ifdef SEG7_BLINK_EN
    for (int i = 0; i < 6; i++) begin
      check($sformatf("blink_alt_%0d", i), 32'(d[i + 2]), 32'(!d[i]));
    end
    check("blink_dark_count", 32'(n_dark), 32'd4);
`endif
    wait_an(2'b11, "bl_end_gap");
    wait_an(2'b10, "bl_end_units");
    blink = 1'b0;
    step();
    check("blink_off_restore", 32'(seg), 32'h78);

    // Long run for anode overlap
    repeat (1000) step();
    check("an_never_00", 32'(an_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
